// File: rtl/output_port_scheduler.sv
// Round-robin, packet-granular scheduler for one router output port shared by
// five inputs (L, N, E, W, S), with credit gating and a stall watchdog.
module output_port_scheduler #(
   parameter int CREDITS = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  req,
   input  logic [14:0] flit_id,
   input  logic        credit_in,
   output logic [4:0]  grant,
   output logic [2:0]  sel,
   output logic        xfer,
   output logic [3:0]  credit_cnt,
   output logic        busy,
   output logic        timeout_err,
   output logic        credit_err
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam logic [3:0]  CRED_MAX  = 4'(CREDITS);
   localparam logic [11:0] STALL_MAX = 12'(TIMEOUT);

   state_t      state;
   logic [2:0]  ptr;
   logic [11:0] stall_cnt;

   logic [4:0]  elig;
   logic        win_vld;
   logic [2:0]  win_idx;
   logic [3:0]  idx;
   logic        g_req;
   logic        g_tail;
   logic [2:0]  next_ptr;
   logic        unused_body_bits;

   // The body bit carries no control meaning; any granted flit is forwarded.
   assign unused_body_bits = ^{flit_id[13], flit_id[10], flit_id[7], flit_id[4], flit_id[1]};

   // req[i] is the valid of port i and xfer is the accept for the granted
   // port: a flit moves only in a cycle where both are high.
   always_comb begin
      g_req  = 1'b0;
      g_tail = 1'b0;
      case (sel)
         3'd0: begin g_req = req[0]; g_tail = flit_id[2];  end
         3'd1: begin g_req = req[1]; g_tail = flit_id[5];  end
         3'd2: begin g_req = req[2]; g_tail = flit_id[8];  end
         3'd3: begin g_req = req[3]; g_tail = flit_id[11]; end
         3'd4: begin g_req = req[4]; g_tail = flit_id[14]; end
         default: ;
      endcase
   end

   assign xfer     = (state == ACTIVE) && g_req && (credit_cnt != 4'd0);
   assign busy     = (state == ACTIVE);
   assign next_ptr = (sel == 3'd4) ? 3'd0 : sel + 3'd1;

   // Rotating scan starting at ptr; only header flits compete.
   always_comb begin
      elig    = '0;
      win_vld = 1'b0;
      win_idx = 3'd0;
      idx     = 4'd0;
      for (int i = 0; i < 5; i++) begin
         elig[i] = req[i] & flit_id[3*i];
      end
      for (int k = 0; k < 5; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'd5) begin
            idx = idx - 4'd5;
         end
         if (!win_vld && elig[idx[2:0]]) begin
            win_vld = 1'b1;
            win_idx = idx[2:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         sel         <= '0;
         ptr         <= '0;
         credit_cnt  <= CRED_MAX;
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
         credit_err  <= 1'b0;
      end else begin
         timeout_err <= 1'b0;

         if (xfer && !credit_in) begin
            credit_cnt <= credit_cnt - 4'd1;
         end else if (credit_in && !xfer) begin
            if (credit_cnt == CRED_MAX) begin
               credit_err <= 1'b1;
            end else begin
               credit_cnt <= credit_cnt + 4'd1;
            end
         end

         case (state)
            IDLE: begin
               if (win_vld) begin
                  state     <= ACTIVE;
                  grant     <= 5'b00001 << win_idx;
                  sel       <= win_idx;
                  stall_cnt <= '0;
               end
            end
            ACTIVE: begin
               if (xfer) begin
                  stall_cnt <= '0;
                  if (g_tail) begin
                     state <= IDLE;
                     grant <= '0;
                     sel   <= '0;
                     ptr   <= next_ptr;
                  end
               end else if (stall_cnt == STALL_MAX) begin
                  // Watchdog: abandon the stalled packet and move priority on.
                  state       <= IDLE;
                  grant       <= '0;
                  sel         <= '0;
                  ptr         <= next_ptr;
                  timeout_err <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + 12'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
